// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared widths, instruction field positions and fetch FSM states
package cpu_pipe_pkg;
  localparam int PC_W_DEF    = 9;
  localparam int INSTR_W_DEF = 16;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 13;
  localparam int OP_HI   = 12;
  localparam int OP_LO   = 11;
  localparam int COND_HI = 10;
  localparam int COND_LO = 8;
  localparam logic [2:0] OPC_HALT = 3'b111;
  typedef enum logic {RUN, HALT} if_state_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: synchronous instruction-memory read port
interface if_stage_if #(
  parameter int PC_W    = cpu_pipe_pkg::PC_W_DEF,
  parameter int INSTR_W = cpu_pipe_pkg::INSTR_W_DEF
);
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_rdata;
  modport master (output imem_addr, output imem_rd, input imem_rdata);
  modport slave  (input imem_addr, input imem_rd, output imem_rdata);
endinterface

// File: rtl/if_stage_skid_buf.sv
// if_skid_buf: one-entry holding register catching a fetch response during stall
module if_skid_buf #(
  parameter int PC_W    = cpu_pipe_pkg::PC_W_DEF,
  parameter int INSTR_W = cpu_pipe_pkg::INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               load,
  input  logic               unload,
  input  logic               clear,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [PC_W-1:0]    d_pc_plus1,
  output logic               q_valid,
  output logic [INSTR_W-1:0] q_instr,
  output logic [PC_W-1:0]    q_pc_plus1
);
  // occupancy: clear wins, then load, then unload
  always_ff @(posedge clk)
    if (Reset || clear) q_valid <= 1'b0;
    else if (load) q_valid <= 1'b1;
    else if (unload) q_valid <= 1'b0;
  // payload only changes on load
  always_ff @(posedge clk)
    if (Reset) begin
      q_instr    <= '0;
      q_pc_plus1 <= '0;
    end else if (load) begin
      q_instr    <= d_instr;
      q_pc_plus1 <= d_pc_plus1;
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: PC, instruction fetch, IF/ID register with skid, flush and HALT handling
module if_stage
  import cpu_pipe_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_pc,
  if_stage_if.master         imem,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc_plus1,
  output logic [2:0]         id_opCode,
  output logic [1:0]         id_op,
  output logic [2:0]         id_cond,
  output logic               halted
);
  if_state_t          state, state_nx;
  logic [PC_W-1:0]    pc, inflight_pc, resp_pc_plus1;
  logic               inflight, resp, halt_cap, issue;
  logic               skid_load, skid_unload, skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc_plus1;

  // a response is only usable while running and not being redirected or reset
  always_comb begin
    resp          = inflight & (state == RUN) & ~flush & ~Reset;
    resp_pc_plus1 = inflight_pc + 1'b1;
    halt_cap      = resp & (imem.imem_rdata[OPC_HI:OPC_LO] == OPC_HALT);
    issue         = (state == RUN) & ~stall & ~flush & ~Reset & ~halt_cap;
    state_nx      = flush ? RUN : halt_cap ? HALT : state;
    skid_load     = resp & stall;
    skid_unload   = ~stall & ~flush & skid_valid;
  end

  // fetch FSM state register
  always_ff @(posedge clk)
    if (Reset) state <= RUN;
    else state <= state_nx;

  // PC advance, redirect and in-flight tracking
  always_ff @(posedge clk)
    if (Reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (flush) pc <= flush_pc;
      else if (issue) begin
        pc          <= pc + 1'b1;
        inflight_pc <= pc;
      end
    end

  // IF/ID register: skid drains first, then a fresh response, else a bubble
  always_ff @(posedge clk)
    if (Reset) begin
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc_plus1 <= '0;
    end else if (flush) id_valid <= 1'b0;
    else if (!stall) begin
      id_valid <= skid_valid | resp;
      if (skid_valid) begin
        id_instr    <= skid_instr;
        id_pc_plus1 <= skid_pc_plus1;
      end else if (resp) begin
        id_instr    <= imem.imem_rdata;
        id_pc_plus1 <= resp_pc_plus1;
      end
    end

  if_skid_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
    .clk        (clk),
    .Reset      (Reset),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (flush),
    .d_instr    (imem.imem_rdata),
    .d_pc_plus1 (resp_pc_plus1),
    .q_valid    (skid_valid),
    .q_instr    (skid_instr),
    .q_pc_plus1 (skid_pc_plus1)
  );

  assign imem.imem_addr = pc;
  assign imem.imem_rd   = issue;
  assign halted         = (state == HALT);
  assign id_opCode      = id_instr[OPC_HI:OPC_LO];
  assign id_op          = id_instr[OP_HI:OP_LO];
  assign id_cond        = id_instr[COND_HI:COND_LO];
endmodule
